// File: rtl/towers_pkg.sv
// Shared definitions for the falling-towers layer: spawn FSM states,
// LFSR feedback taps and screen/tower geometry.
package towers_pkg;

  typedef enum logic [1:0] {
    ST_DRAW   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_READY  = 2'd3
  } spawn_state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam int          SCREEN_WIDTH = 640;
  localparam int          TOWER_WIDTH  = 28;

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with a step enable, seed load on reset
// and a guard that reloads the seed if the sequence ever reaches zero.
module lfsr16_galois
  import towers_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_step,
  output logic [15:0] o_state,
  output logic [15:0] o_next
);

  logic [15:0] r_state;
  logic [15:0] w_raw_next;

  assign w_raw_next = (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
  assign o_next     = (w_raw_next == 16'h0000) ? SEED : w_raw_next;
  assign o_state    = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= o_next;
    end
  end

endmodule

// File: rtl/towers_spawn_gen.sv
// Spawn-column generator: draws LFSR values, folds them into the legal
// window, enforces a minimum gap from the last published column and
// publishes one validated candidate per unpaused startOfFrame.
module towers_spawn_gen
  import towers_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          SPAWN_MIN  = 0,
  parameter int          SPAWN_MAX  = SCREEN_WIDTH - TOWER_WIDTH,
  parameter int          SPAWN_INIT = 292,
  parameter int          MIN_GAP    = 64,
  parameter int          MAX_RETRY  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               pause,
  output logic signed [10:0] spawnX,
  output logic               spawnStrobe,
  output logic               candReady
);

  localparam int                    RANGE     = SPAWN_MAX - SPAWN_MIN + 1;
  localparam logic [10:0]           RANGE_V   = 11'(RANGE);
  localparam logic signed [11:0]    MIN_S     = 12'(SPAWN_MIN);
  localparam logic signed [11:0]    MAX_S     = 12'(SPAWN_MAX);
  localparam logic signed [11:0]    GAP_S     = 12'(MIN_GAP);
  localparam logic signed [10:0]    INIT_S    = 11'(SPAWN_INIT);
  localparam int                    RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIM = RETRY_W'(MAX_RETRY);

  spawn_state_t        r_state;
  logic [9:0]          r_v;
  logic signed [10:0]  r_cand;
  logic signed [10:0]  r_last;
  logic signed [10:0]  r_spawn_x;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_strobe;
  logic                r_ready;

  logic                w_step;
  logic [15:0]         w_lfsr_state;
  logic [15:0]         w_lfsr_next;
  logic [10:0]         w_v_ext;
  logic [10:0]         w_reduced;
  logic signed [11:0]  w_cand_new;
  logic signed [11:0]  w_cand_ext;
  logic signed [11:0]  w_last_ext;
  logic signed [11:0]  w_diff;
  logic signed [11:0]  w_dist;
  logic signed [11:0]  w_fwd;
  logic signed [11:0]  w_bwd;
  logic signed [10:0]  w_forced;
  logic                w_unused;

  assign w_step = (r_state == ST_DRAW);

  lfsr16_galois #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_step  (w_step),
    .o_state (w_lfsr_state),
    .o_next  (w_lfsr_next)
  );

  assign w_v_ext    = {1'b0, r_v};
  assign w_reduced  = w_v_ext - RANGE_V;
  assign w_cand_new = MIN_S + $signed({2'b00, r_v});

  // Distances are taken one bit wider so |cand - last| can never wrap.
  assign w_cand_ext = {r_cand[10], r_cand};
  assign w_last_ext = {r_last[10], r_last};
  assign w_diff     = w_cand_ext - w_last_ext;
  assign w_dist     = w_diff[11] ? -w_diff : w_diff;
  assign w_fwd      = w_last_ext + GAP_S;
  assign w_bwd      = w_last_ext - GAP_S;
  assign w_forced   = (w_fwd <= MAX_S) ? w_fwd[10:0] : w_bwd[10:0];

  assign w_unused = &{1'b0, w_lfsr_state, w_lfsr_next[15:10], w_reduced[10], w_cand_new[11]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_DRAW;
      r_v       <= '0;
      r_cand    <= INIT_S;
      r_last    <= INIT_S;
      r_spawn_x <= INIT_S;
      r_retry   <= '0;
      r_strobe  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_DRAW: begin
          r_v     <= w_lfsr_next[9:0];
          r_retry <= r_retry + RETRY_W'(1);
          r_state <= ST_REDUCE;
        end
        ST_REDUCE: begin
          if (w_v_ext >= RANGE_V) begin
            r_v <= w_reduced[9:0];
          end else begin
            r_cand  <= w_cand_new[10:0];
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_dist >= GAP_S) begin
            r_ready <= 1'b1;
            r_state <= ST_READY;
          end else if (r_retry == RETRY_LIM) begin
            r_cand  <= w_forced;
            r_ready <= 1'b1;
            r_state <= ST_READY;
          end else begin
            r_state <= ST_DRAW;
          end
        end
        ST_READY: begin
          if (startOfFrame && !pause) begin
            r_spawn_x <= r_cand;
            r_last    <= r_cand;
            r_strobe  <= 1'b1;
            r_ready   <= 1'b0;
            r_retry   <= '0;
            r_state   <= ST_DRAW;
          end
        end
        default: r_state <= ST_DRAW;
      endcase
    end
  end

  assign spawnX      = r_spawn_x;
  assign spawnStrobe = r_strobe;
  assign candReady   = r_ready;

endmodule

// File: tb/tb_towers_spawn_gen.sv
// Scoreboard bench for towers_spawn_gen: stimulus pushes expected columns,
// per-instance monitors pop and compare on every spawnStrobe.
module tb_towers_spawn_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1;
  logic               sof0 = 1'b0, sof1 = 1'b0;
  logic               pause0 = 1'b0;
  logic               pause1 = 1'b0;
  logic signed [10:0] spawn_x0, spawn_x1;
  logic               strobe0, strobe1;
  logic               ready0, ready1;

  towers_spawn_gen dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof0),
    .pause        (pause0),
    .spawnX       (spawn_x0),
    .spawnStrobe  (strobe0),
    .candReady    (ready0)
  );

  towers_spawn_gen #(
    .MIN_GAP   (300),
    .MAX_RETRY (1)
  ) dut_gap (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof1),
    .pause        (pause1),
    .spawnX       (spawn_x1),
    .spawnStrobe  (strobe1),
    .candReady    (ready1)
  );

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];

  // Reference model: one call yields the next published column.
  int m_lfsr[2];
  int m_last[2];
  int m_gap[2]   = '{64, 300};
  int m_retry[2] = '{8, 1};
  int mon_last[2] = '{292, 292};

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1;
      m_last[i] = 292;
    end
  endtask

  task automatic model_next(input int idx, output int val);
    int cand;
    int tries;
    int d;
    tries = 0;
    forever begin
      m_lfsr[idx] = (m_lfsr[idx] >> 1) ^ (((m_lfsr[idx] & 1) != 0) ? 32'hB400 : 32'h0);
      if (m_lfsr[idx] == 0) m_lfsr[idx] = 16'hACE1;
      cand  = (m_lfsr[idx] & 32'h3FF) % 613;
      tries = tries + 1;
      d = cand - m_last[idx];
      if (d < 0) d = -d;
      if (d >= m_gap[idx]) break;
      if (tries == m_retry[idx]) begin
        cand = (m_last[idx] + m_gap[idx] <= 612) ? m_last[idx] + m_gap[idx]
                                                  : m_last[idx] - m_gap[idx];
        break;
      end
    end
    m_last[idx] = cand;
    val = cand;
  endtask

  task automatic mon_strobe(input int idx, input int x, input logic rdy);
    int exp;
    int d;
    checks++;
    if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL stray_strobe%0d: got strobe with spawnX=%0d expected no strobe", idx, x);
    end else begin
      exp = (idx == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("spawnX%0d", idx), x, exp);
    end
    chk($sformatf("ready_drop%0d", idx), int'(rdy), 0);
    checks++;
    if (x < 0 || x > 612) begin
      errors++;
      $display("FAIL range%0d: got %0d expected within 0..612", idx, x);
    end
    d = x - mon_last[idx];
    if (d < 0) d = -d;
    checks++;
    if (d < m_gap[idx]) begin
      errors++;
      $display("FAIL gap%0d: got |delta|=%0d expected >= %0d", idx, d, m_gap[idx]);
    end
    mon_last[idx] = x;
  endtask

  always @(negedge clk) begin
    if (reset) mon_last[0] = 292;
    else if (strobe0) mon_strobe(0, int'(spawn_x0), ready0);
  end

  always @(negedge clk) begin
    if (reset) mon_last[1] = 292;
    else if (strobe1) mon_strobe(1, int'(spawn_x1), ready1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // mode 0: pulse only; 1: push model value; 2: push hand value, advance model
  task automatic pulse(input int idx, input int mode, input int hand);
    int val;
    if (mode != 0) begin
      model_next(idx, val);
      if (mode == 2) val = hand;
      if (idx == 0) q0.push_back(val);
      else q1.push_back(val);
    end
    if (idx == 0) sof0 = 1'b1;
    else sof1 = 1'b1;
    tick();
    sof0 = 1'b0;
    sof1 = 1'b0;
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (!((idx == 0) ? ready0 : ready1) && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("ready_timeout%0d", idx), int'((idx == 0) ? ready0 : ready1), 1);
  endtask

  initial begin
    // Reset state and release sequence
    tick();
    tick();
    chk("rst_spawnX", int'(spawn_x0), 292);
    chk("rst_strobe", int'(strobe0), 0);
    chk("rst_ready", int'(ready0), 0);
    chk("rst_ready_gap", int'(ready1), 0);
    model_reset();
    reset = 1'b0;
    repeat (3) tick();
    chk("ready_early", int'(ready0), 0);
    tick();
    chk("ready_at4", int'(ready0), 1);
    chk("spawnX_before_pub", int'(spawn_x0), 292);
    pulse(0, 2, 11);
    tick();

    // Frame pulse while computing is dropped, no catch-up later
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    pulse(0, 0, 0);
    chk("busy_strobe", int'(strobe0), 0);
    chk("busy_spawnX", int'(spawn_x0), 292);
    wait_ready(0);
    repeat (6) tick();
    chk("no_catchup", int'(spawn_x0), 292);
    pulse(0, 2, 11);

    // Pause holds the candidate across several frames
    wait_ready(0);
    pause0 = 1'b1;
    repeat (5) begin
      pulse(0, 0, 0);
      repeat (8) tick();
    end
    chk("pause_spawnX", int'(spawn_x0), 11);
    chk("pause_ready", int'(ready0), 1);
    pause0 = 1'b0;
    pulse(0, 1, 0);
    wait_ready(0);
    pulse(0, 1, 0);

    // Reset while in REDUCE restarts the release sequence
    wait_ready(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_spawnX", int'(spawn_x0), 292);
    chk("midrst_strobe", int'(strobe0), 0);
    chk("midrst_ready", int'(ready0), 0);
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("midrst_ready_early", int'(ready0), 0);
    tick();
    chk("midrst_ready_at4", int'(ready0), 1);
    pulse(0, 2, 11);

    // Wide gap with a single retry forces placement
    wait_ready(1);
    pulse(1, 2, 592);
    repeat (150) begin
      wait_ready(1);
      pulse(1, 1, 0);
    end

    // Long run against the reference model
    repeat (3000) begin
      wait_ready(0);
      pulse(0, 1, 0);
    end

    repeat (4) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
